// File: rtl/seg_pkg.sv
// seg_pkg: shared types and glyph constants for the 7-segment scan decoder
package seg_pkg;
  localparam int NUM_DIGITS = 5;
  localparam logic [6:0] BLANK_GLYPH = 7'h00;
  localparam logic [6:0] GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;
endpackage

// File: rtl/seg_glyph_decode.sv
// seg_glyph_decode: maps a g..a segment pattern to its hex nibble, blank or unknown
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [6:0] i_glyph,
  output logic [3:0] o_nibble,
  output logic       o_blank,
  output logic       o_unknown
);
  always_comb begin
    o_nibble  = '0;
    o_blank   = i_glyph == BLANK_GLYPH;
    o_unknown = i_glyph != BLANK_GLYPH;
    for (int k = 0; k < 16; k++)
      if (i_glyph == GLYPHS[k]) begin
        o_nibble  = 4'(k);
        o_unknown = 1'b0;
      end
  end
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a multiplexed 5-digit 7-segment scan and publishes whole frames atomically
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 400000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   sev_sel,
  input  logic [7:0]              sev_data,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic [NUM_DIGITS-1:0]   dp,
  output logic                    frame_valid,
  output logic                    frame_err,
  output logic                    stale
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);
  state_t                  r_state;
  logic [7:0]              r_cnt, r_data_q;
  logic [NUM_DIGITS-1:0]   r_sel_q, r_mask, r_sh_blank, r_sh_dp, r_blank, r_dp;
  logic [4*NUM_DIGITS-1:0] r_sh_dig, r_digits;
  logic                    r_sh_err, r_err, r_fv, r_stale;
  logic [TW-1:0]           r_to, w_to_nxt;
  logic [3:0]              w_nib;
  logic                    w_blank, w_unknown, w_onehot, w_bad, w_chg, w_rescan, w_cap, w_full;
  seg_glyph_decode u_dec (
    .i_glyph  (sev_data[6:0]),
    .o_nibble (w_nib),
    .o_blank  (w_blank),
    .o_unknown(w_unknown)
  );
  assign w_onehot = $countones(sev_sel) == 1;
  assign w_bad    = (sev_sel != '0) && !w_onehot;
  assign w_chg    = (sev_sel != r_sel_q) || (sev_data != r_data_q);
  // IDLE and any input change in SETTLE/HELD share the same select evaluation
  assign w_rescan = (r_state == IDLE) || w_chg;
  assign w_cap    = (r_state == SETTLE) && !w_chg && (r_cnt == CNT_LAST);
  assign w_full   = &r_mask;
  assign w_to_nxt = w_full ? '0 : (r_to == TO_MAX) ? r_to : r_to + TW'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_sel_q    <= '0;
      r_data_q   <= '0;
      r_mask     <= '0;
      r_sh_dig   <= '0;
      r_sh_blank <= '0;
      r_sh_dp    <= '0;
      r_sh_err   <= 1'b0;
      r_to       <= '0;
      r_digits   <= '0;
      r_blank    <= '1;
      r_dp       <= '0;
      r_err      <= 1'b0;
      r_fv       <= 1'b0;
      r_stale    <= 1'b0;
    end else begin
      r_sel_q  <= sev_sel;
      r_data_q <= sev_data;
      if (w_rescan) begin
        r_state <= w_onehot ? SETTLE : IDLE;
        r_cnt   <= 8'd1;
      end else if (r_state == SETTLE) begin
        r_state <= w_cap ? HELD : SETTLE;
        r_cnt   <= r_cnt + 8'd1;
      end
      for (int i = 0; i < NUM_DIGITS; i++)
        if (w_cap && sev_sel[i]) begin
          r_sh_dig[4*i +: 4] <= w_nib;
          r_sh_blank[i]      <= w_blank;
          r_sh_dp[i]         <= sev_data[7];
        end
      // a publish edge starts a fresh frame, so only this edge's events survive it
      r_mask   <= (w_full ? '0 : r_mask) | (w_cap ? sev_sel : '0);
      r_sh_err <= (!w_full && r_sh_err) || (w_rescan && w_bad) || (w_cap && w_unknown);
      r_to     <= w_to_nxt;
      r_stale  <= !w_full && (w_to_nxt == TO_MAX);
      r_fv     <= w_full;
      if (w_full) begin
        r_digits <= r_sh_dig;
        r_blank  <= r_sh_blank;
        r_dp     <= r_sh_dp;
        r_err    <= r_sh_err;
      end
    end
  end
  assign digits      = r_digits;
  assign blank       = r_blank;
  assign dp          = r_dp;
  assign frame_valid = r_fv;
  assign frame_err   = r_err;
  assign stale       = r_stale;
endmodule
